// File: rtl/bunch_event_counter_pkg.sv
// Shared widths, LHC constants and the trigger-record layout for the bunch/event counter.
// No logic; no latency; no backpressure.
// Pure definitions, imported by every file of this block.
package bunch_counter_pkg;

    localparam int LHC_ORBIT_LEN = 3564;
    localparam int DEF_BUNCH_W   = 12;
    localparam int DEF_EVENT_W   = 24;
    localparam int DEF_ORBIT_W   = 16;

    // Record in default widths; parametrised instances pack the same field order.
    typedef struct packed {
        logic [DEF_EVENT_W-1:0] evt;
        logic [DEF_BUNCH_W-1:0] bunch;
        logic [DEF_ORBIT_W-1:0] orbit;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    function automatic int rec_width(input int event_w, input int bunch_w, input int orbit_w);
        return event_w + bunch_w + orbit_w;
    endfunction

endpackage

// File: rtl/bunch_event_counter_if.sv
// Trigger-record valid/ready channel toward the readout packetiser.
// No logic; no latency; backpressure via rec_ready.
// master drives the record, slave consumes it.
interface bunch_event_counter_if
    import bunch_counter_pkg::*;
#(
    parameter int EVENT_W = DEF_EVENT_W,
    parameter int BUNCH_W = DEF_BUNCH_W,
    parameter int ORBIT_W = DEF_ORBIT_W
);
    logic               rec_valid;
    logic               rec_ready;
    logic [EVENT_W-1:0] rec_event;
    logic [BUNCH_W-1:0] rec_bunch;
    logic [ORBIT_W-1:0] rec_orbit;

    modport master (output rec_valid, rec_event, rec_bunch, rec_orbit, input rec_ready);
    modport slave  (input rec_valid, rec_event, rec_bunch, rec_orbit, output rec_ready);
endinterface

// File: rtl/bunch_event_counter_record_fifo.sv
// Generic synchronous first-word-fall-through FIFO with full/empty.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes refused when full unless a read happens in the same cycle.
module bec_record_fifo #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld  = !empty;
    assign rd_fire = rd_rdy && !empty;
    assign wr_fire = wr_vld && (!full || rd_fire);
    // Gate the head word so a flushed FIFO presents zeros rather than stale data.
    assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/bunch_event_counter.sv
// LHC bunch/orbit/event counter stamping L1 triggers into a record FIFO; BUNCH_ORBIT_CHECK_EN adds the BC0 phase check.
// Latency: counters update on the edge after their strobe; a record reaches rec_valid one cycle after t1.
// Backpressure: rec_ready stalls the FIFO; triggers arriving while full are dropped and counted.
module bunch_event_counter
    import bunch_counter_pkg::*;
#(
    parameter int BUNCH_W    = DEF_BUNCH_W,
    parameter int EVENT_W    = DEF_EVENT_W,
    parameter int ORBIT_W    = DEF_ORBIT_W,
    parameter int ORBIT_LEN  = LHC_ORBIT_LEN,
    parameter int BC0_OFFSET = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bc_tick,
    input  logic                  bc0,
    input  logic                  ec0,
    input  logic                  t1,
    output logic [BUNCH_W-1:0]    bunch_number,
    output logic [ORBIT_W-1:0]    orbit_number,
    output logic [EVENT_W-1:0]    event_number,
    bunch_event_counter_if.master rec,
    output logic                  fifo_ovf,
    output logic [7:0]            drop_count,
    output logic                  orbit_err
);
    localparam int                 RW       = rec_width(EVENT_W, BUNCH_W, ORBIT_W);
    localparam logic [BUNCH_W-1:0] WRAP_VAL = BUNCH_W'(ORBIT_LEN - 1);
    localparam logic [BUNCH_W-1:0] OFFSET   = BUNCH_W'(BC0_OFFSET);

    logic               at_wrap;
    logic               orbit_inc;
    logic [EVENT_W-1:0] event_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               drop;
    logic [RW-1:0]      rd_dat;

    assign at_wrap   = (bunch_number == WRAP_VAL);
    // bc0 and the natural wrap coincide on a well-phased orbit: count it once.
    assign orbit_inc = bc_tick && (bc0 || at_wrap);

    always_comb begin
        event_next = event_number;
        if (ec0)     event_next = t1 ? EVENT_W'(1) : '0;
        else if (t1) event_next = event_number + EVENT_W'(1);
    end

    assign pop  = rec.rec_valid && rec.rec_ready;
    assign push = t1 && (!fifo_full || pop);
    assign drop = t1 && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bunch_number <= '0;
            orbit_number <= '0;
            event_number <= '0;
            fifo_ovf     <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (bc_tick) begin
                if (bc0)          bunch_number <= OFFSET;
                else if (at_wrap) bunch_number <= '0;
                else              bunch_number <= bunch_number + BUNCH_W'(1);
            end
            if (orbit_inc) orbit_number <= orbit_number + ORBIT_W'(1);
            event_number <= event_next;
            if (drop) begin
                fifo_ovf <= 1'b1;
                if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Stamp uses the registered (pre-update) bunch/orbit of the trigger cycle.
    bec_record_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat ({event_next, bunch_number, orbit_number}),
        .rd_rdy (rec.rec_ready),
        .rd_vld (rec.rec_valid),
        .rd_dat (rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign {rec.rec_event, rec.rec_bunch, rec.rec_orbit} = rd_dat;

`ifdef BUNCH_ORBIT_CHECK_EN
    logic bc0_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc0_seen  <= 1'b0;
            orbit_err <= 1'b0;
        end else if (bc_tick && bc0) begin
            bc0_seen <= 1'b1;
            if (bc0_seen && !at_wrap) orbit_err <= 1'b1;
        end
    end
`else
    assign orbit_err = 1'b0;
`endif

endmodule

// File: tb/tb_bunch_event_counter.sv
// Randomised and directed bench for bunch_event_counter against a queue-based reference model.
module tb_bunch_event_counter;
    import bunch_counter_pkg::*;

    localparam int BW = 12, EW = 24, OW = 16, OL = 16, OFF = 0, DEPTH = 8;
    localparam int RW = EW + BW + OW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bc_tick = 1'b0, bc0 = 1'b0, ec0 = 1'b0, t1 = 1'b0;
    logic [BW-1:0] bunch_number;
    logic [OW-1:0] orbit_number;
    logic [EW-1:0] event_number;
    logic          fifo_ovf;
    logic [7:0]    drop_count;
    logic          orbit_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            m_bunch, m_orbit, m_drops;
    logic [EW-1:0] m_event;
    logic [RW-1:0] m_q[$];
    bit            m_ovf, m_seen, m_err;

    always #5 clk = ~clk;

    bunch_event_counter_if #(.EVENT_W(EW), .BUNCH_W(BW), .ORBIT_W(OW)) rec_if ();

    bunch_event_counter #(
        .BUNCH_W(BW), .EVENT_W(EW), .ORBIT_W(OW),
        .ORBIT_LEN(OL), .BC0_OFFSET(OFF), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bc_tick(bc_tick), .bc0(bc0), .ec0(ec0), .t1(t1),
        .bunch_number(bunch_number), .orbit_number(orbit_number), .event_number(event_number),
        .rec(rec_if), .fifo_ovf(fifo_ovf), .drop_count(drop_count), .orbit_err(orbit_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bunch = 0; m_orbit = 0; m_event = '0; m_q.delete();
        m_ovf = 0; m_drops = 0; m_seen = 0; m_err = 0;
    endtask

    task automatic check_all(input string ph);
        bit exp_err;
`ifdef BUNCH_ORBIT_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        check({ph, ".bunch"}, 64'(bunch_number), 64'(m_bunch));
        check({ph, ".orbit"}, 64'(orbit_number), 64'(m_orbit));
        check({ph, ".event"}, 64'(event_number), 64'(m_event));
        check({ph, ".valid"}, 64'(rec_if.rec_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0)
            check({ph, ".rec"}, 64'({rec_if.rec_event, rec_if.rec_bunch, rec_if.rec_orbit}), 64'(m_q[0]));
        check({ph, ".ovf"}, 64'(fifo_ovf), 64'(m_ovf));
        check({ph, ".drops"}, 64'(drop_count), 64'(m_drops));
        check({ph, ".orbit_err"}, 64'(orbit_err), 64'(exp_err));
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic step(input string ph, input bit tick, input bit b0, input bit e0,
                        input bit trig, input bit rdy);
        bit            pop;
        logic [EW-1:0] ev_n;
        logic [RW-1:0] rec;
        int            nb, no;
        @(negedge clk);
        bc_tick = tick; bc0 = b0; ec0 = e0; t1 = trig; rec_if.rec_ready = rdy;
        pop  = rdy && (m_q.size() > 0);
        ev_n = e0 ? EW'(trig) : (trig ? m_event + EW'(1) : m_event);
        rec  = {ev_n, BW'(m_bunch), OW'(m_orbit)};
        nb = m_bunch; no = m_orbit;
        if (tick && b0) begin
            if (m_seen && m_bunch != OL - 1) m_err = 1;
            m_seen = 1;
            nb = OFF; no = (m_orbit + 1) % 65536;
        end else if (tick) begin
            nb = (m_bunch + 1) % OL;
            if (nb == 0) no = (m_orbit + 1) % 65536;
        end
        @(posedge clk);
        #1;
        m_bunch = nb; m_orbit = no; m_event = ev_n;
        if (pop) void'(m_q.pop_front());
        if (trig) begin
            if (m_q.size() < DEPTH) m_q.push_back(rec);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        check_all(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        bc_tick = 0; bc0 = 0; ec0 = 0; t1 = 0; rec_if.rec_ready = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rec_if.rec_ready = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // free-running bunch counter across an orbit wrap
        for (int i = 0; i < 20; i++) step("sweep", 1, 0, 0, 0, 1);
        check("sweep_bunch", 64'(bunch_number), 64'd4);
        check("sweep_orbit", 64'(orbit_number), 64'd1);

        // bc0 at bunch 7: first bc0 is exempt from the phase check, the second is not
        for (int i = 0; i < 3; i++) step("to7", 1, 0, 0, 0, 1);
        step("bc0_a", 1, 1, 0, 0, 1);
        check("bc0_a_bunch", 64'(bunch_number), 64'd0);
        check("bc0_a_orbit", 64'(orbit_number), 64'd2);
        for (int i = 0; i < 7; i++) step("to7b", 1, 0, 0, 0, 1);
        step("bc0_b", 1, 1, 0, 0, 1);
        check("bc0_b_orbit", 64'(orbit_number), 64'd3);
`ifdef BUNCH_ORBIT_CHECK_EN
        check("bc0_b_err", 64'(orbit_err), 64'd1);
`endif

        // stamped trigger at bunch 5, orbit 2
        do_reset();
        for (int i = 0; i < 37; i++) step("to5", 1, 0, 0, 0, 1);
        step("trig", 0, 0, 0, 1, 1);
        check("trig_event", 64'(rec_if.rec_event), 64'd1);
        check("trig_bunch", 64'(rec_if.rec_bunch), 64'd5);
        check("trig_orbit", 64'(rec_if.rec_orbit), 64'd2);
        step("trig_pop", 0, 0, 0, 0, 1);

        // overflow burst and ordered drain
        do_reset();
        for (int i = 0; i < 10; i++) step("burst", 1, 0, 0, 1, 0);
        check("burst_drops", 64'(drop_count), 64'd2);
        check("burst_ovf", 64'(fifo_ovf), 64'd1);
        check("burst_event", 64'(event_number), 64'd10);
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 64'(rec_if.rec_event), 64'(i));
            step("drain", 1, 0, 0, 0, 1);
        end
        check("drain_empty", 64'(rec_if.rec_valid), 64'd0);

        // ec0 together with t1
        for (int i = 0; i < 5; i++) step("ev5", 0, 0, 0, 1, 1);
        step("ec0_t1", 0, 0, 1, 1, 1);
        check("ec0_event", 64'(event_number), 64'd1);
        check("ec0_rec", 64'(rec_if.rec_event), 64'd1);

        // reset with records queued, then restart numbering
        for (int i = 0; i < 3; i++) step("queue3", 1, 0, 0, 1, 0);
        do_reset();
        step("post_rst", 0, 0, 0, 1, 0);
        check("post_rst_event", 64'(rec_if.rec_event), 64'd1);

        // drop counter saturation
        for (int i = 0; i < 300; i++) step("sat", 0, 0, 0, 1, 0);
        check("sat_drops", 64'(drop_count), 64'd255);
        do_reset();

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit tk;
            tk = ($urandom_range(0, 3) != 0);
            step("rand", tk, tk && ($urandom_range(0, 19) == 0), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bunch_event_counter.md
Name: bunch_event_counter

Overview:
Parametrised successor to the single-channel bunch/event counter. Tracks LHC bunch crossing number, orbit number and L1 event number in the system clock domain. Stamps each L1 trigger with {event, bunch, orbit} and queues the record in a small FIFO with a valid/ready handshake toward the readout/USB packetiser.

Parameters:
BUNCH_W, 12, bunch counter width; must satisfy 2^BUNCH_W >= ORBIT_LEN
EVENT_W, 24, event counter width
ORBIT_W, 16, orbit counter width
ORBIT_LEN, 3564, bunch crossings per orbit
BC0_OFFSET, 0, value loaded into the bunch counter on bc0
FIFO_DEPTH, 8, trigger-record FIFO depth; power of 2, >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
bc_tick  in  1  one-clk strobe per bunch crossing, already synchronised to clk
bc0  in  1  orbit marker; qualified by bc_tick
ec0  in  1  event-counter reset strobe, one clk
t1  in  1  L1 trigger strobe, one clk
bunch_number  out  BUNCH_W  live bunch count
orbit_number  out  ORBIT_W  live orbit count
event_number  out  EVENT_W  number of the last accepted trigger
rec_valid  out  1  trigger record available
rec_ready  in  1  consumer accepts record
rec_event  out  EVENT_W  record event number
rec_bunch  out  BUNCH_W  record bunch number
rec_orbit  out  ORBIT_W  record orbit number
fifo_ovf  out  1  sticky: a record was dropped
drop_count  out  8  dropped records, saturating at 255
orbit_err  out  1  sticky BC0 phase error (optional feature only, else tied 0)

Behaviour:
- Reset (rst=0, async): all counters, FIFO pointers, flags and outputs go to 0. rec_valid=0.
- Bunch counter: on bc_tick, increments; at ORBIT_LEN-1 wraps to 0. bc_tick&bc0 loads BC0_OFFSET; bc0 overrides wrap. bc0 without bc_tick is ignored.
- Orbit counter: increments on bc_tick&bc0, or on wrap when bc0 is absent. Never increments twice for one tick. Wraps modulo 2^ORBIT_W.
- Event counter: t1 increments it; the first trigger after reset or ec0 is event 1. Wraps modulo 2^EVENT_W; after the maximum value the next event is 0.
- ec0 clears the counter to 0. ec0&t1 in the same cycle: the trigger is numbered 1 and event_number=1.
- Record capture: t1 in cycle N pushes {new event number, bunch_number and orbit_number as registered at N}, i.e. pre-update values. A same-cycle bc_tick does not affect the stamp.
- FIFO: synchronous, first-word-fall-through. Record from t1 at N is visible with rec_valid=1 at N+1 if the FIFO was empty. Pop on rec_valid&rec_ready. Push and pop in the same cycle are both allowed when full.
- FIFO full on t1 without a same-cycle pop: record dropped; event counter still increments; fifo_ovf set (sticky until reset); drop_count increments, saturating.
- rec_* remain stable while rec_valid=1 and rec_ready=0.
- Reset mid-operation flushes the FIFO; records are lost and no flag is set.

Optional Feature:
Macro BUNCH_ORBIT_CHECK_EN.
- Defined: on bc_tick&bc0, compare the expected next bunch value (the wrap point) with the actual count. If bunch_number != ORBIT_LEN-1 and it is not the first bc0 after reset, set orbit_err (sticky until reset).
- Undefined: the check logic is absent and orbit_err is tied to 0.

Decomposition:
- Package bunch_counter_pkg: LHC_ORBIT_LEN=3564, default widths, record struct/typedef {event, bunch, orbit} and its packed width.
- One sub-module: bec_record_fifo, a generic FWFT synchronous FIFO parametrised by width/depth, providing full/empty.

Test Plan:
- ORBIT_LEN=16, bc_tick every clk, no bc0 -> bunch_number 0..15 then 0, orbit_number increments by 1 per wrap.
- bc_tick&bc0 at bunch 7 with BC0_OFFSET=0 -> bunch_number=0 next cycle, orbit +1 once. With BUNCH_ORBIT_CHECK_EN, orbit_err=1 (not the first bc0).
- Reset, then t1 at bunch 5, orbit 2 with rec_ready=1 -> next cycle rec_valid=1, rec_event=1, rec_bunch=5, rec_orbit=2, event_number=1.
- FIFO_DEPTH=8, rec_ready=0, 10 t1 pulses -> 8 records held, fifo_ovf=1, drop_count=2, event_number=10. Drain: events 1..8 in order.
- ec0&t1 in the same cycle after 5 events -> record event 1, event_number=1.
- rst asserted with 3 records queued -> rec_valid=0 and all counters 0 immediately (asynchronous). After release, the next t1 gives rec_event=1.
